rx_buf_scheduler: RTL and testbench
===================================

// Module: rx_buf_scheduler
// PURPOSE
//  Ring-buffer and packet scheduler between rx_fsm (writer) and output_controller (reader) over the shared 80-bit data_mem.
//  Allocates write addresses and commits only good packets. Rolls back aborted/overflowed packets.
//  Queues packet descriptors and hands them to the reader one packet at a time; space is freed on reader release.
// PARAMETERS
//  ADDR_WIDTH     8   data_mem address width; ring holds 2**ADDR_WIDTH words, usable 2**ADDR_WIDTH-1
//  DESC_DEPTH     16  descriptor FIFO depth (power of 2)
//  MAX_PKT_WORDS  20  max 80-bit words per packet; more -> drop
// PORTS
//  clk_in            in   1   clock
//  rst_n_in          in   1   synchronous reset, active low
//  wr_start_in       in   1   pulse: new packet begins
//  wr_word_in        in   1   pulse: writer has one 80-bit word ready
//  wr_commit_in      in   1   pulse: packet ended good
//  wr_last_bytes_in  in   4   valid bytes in last word (1..10), sampled with wr_commit_in
//  wr_abort_in       in   1   pulse: packet ended bad (FCS/rxer)
//  wr_addr_out       out  AW  data_mem write address (comb from wp_s)
//  wr_enabl_out      out  1   data_mem write strobe (comb: wr_word_in & accepted)
//  desc_valid_out    out  1   descriptor offered to reader
//  desc_ready_in     in   1   reader accepts descriptor
//  desc_addr_out     out  AW  first word address
//  desc_words_out    out  8   word count (1..MAX_PKT_WORDS)
//  desc_last_bytes_out out 4  valid bytes in last word
//  rel_in            in   1   pulse: reader finished issued packet
//  stat_drop_cnt     out  16  packets dropped for space/FIFO/length, saturating
// BEHAVIOUR
//  Pointers AW bits, mod 2**AW: wp_c (committed), wp_s (speculative), rp (freed). free = rp - wp_s - 1.
//  Write FSM W_IDLE / W_RECV / W_OVF:
//   - wr_start_in (any state): wp_s<=wp_c, wcnt<=0, ->W_RECV; an unfinished packet is silently rolled back.
//   - W_RECV + wr_word_in:
//     - free>0 and wcnt<MAX_PKT_WORDS: wr_enabl_out=1 at wr_addr_out=wp_s; wp_s++, wcnt++ next cycle.
//     - otherwise: no write, ->W_OVF.
//   - W_OVF: words ignored (wr_enabl_out=0).
//   - wr_commit_in from W_RECV:
//     - wcnt>0 and FIFO not full: push {wp_c,wcnt,last_bytes}, wp_c<=wp_s.
//     - else: wp_s<=wp_c, drop++.
//     - ->W_IDLE.
//   - wr_commit_in from W_OVF: wp_s<=wp_c, drop++, ->W_IDLE.
//   - wr_abort_in (W_RECV/W_OVF): wp_s<=wp_c, ->W_IDLE; not counted (rx_fsm counts errors).
//   - Inputs other than wr_start_in ignored in W_IDLE.
//  Same cycle wr_word_in+wr_commit_in: word is written and included (wcnt+1, wp_s+1 committed). wr_commit_in+wr_abort_in: abort wins.
//  Read FSM R_IDLE / R_OFFER / R_BUSY:
//   - R_IDLE & FIFO not empty -> R_OFFER: head registered on desc_* outputs, desc_valid_out=1.
//   - R_OFFER & desc_ready_in -> pop, latch issued words, R_BUSY; desc_* held stable until accepted.
//   - R_BUSY & rel_in -> rp<=rp+issued words, R_IDLE. rel_in outside R_BUSY ignored.
//   - At most one packet in flight. FIFO-not-empty to desc_valid_out = 1 cycle.
//  Simultaneous push and pop both take effect. rel_in with any write event: both apply; new free visible next cycle.
//  stat_drop_cnt saturates at 16'hFFFF.
//  Reset: all pointers, counters, FIFO empty; desc_valid_out=0, desc_*=0, wr_enabl_out=0, stat_drop_cnt=0; both FSMs idle.
//  Reset mid-packet discards it. Reset has priority over all inputs.
// TESTING
//  1 Reset, start, 3 words, commit lb=4 -> writes addr 0,1,2. Desc {0,3,4} valid 1 cycle after push; ready -> R_BUSY; rel -> rp=3.
//  2 Start, 2 words, abort; start, 1 word, commit -> second packet written at addr 0, desc {0,1,..}, drop=0.
//  3 Start, 21 words (MAX=20), commit -> 20 writes then none, no desc, wp_c unchanged, drop=1.
//  4 Fill ring (no rel): 255 words committed over packets; next packet's first word -> W_OVF, no write, commit -> drop+1. After rel of head, new packet fits.
//  5 Wrap: rp=wp=250, 10-word packet -> addrs 250..255,0..3. Desc addr 250, words 10.
//  6 17 good packets with desc_ready_in=0 -> 16 queued, 17th dropped (drop=1). Push+pop same cycle keeps count; word+commit same cycle includes word.

Source files
------------

// File: rtl/rx_buf_scheduler.sv
// Ring-buffer write-address allocator and packet descriptor scheduler.
// The writer side speculatively fills the ring and commits or rolls back whole
// packets; the reader side is offered one descriptor at a time and frees ring
// space when it releases the packet it was given.
module rx_buf_scheduler #(
    parameter int ADDR_WIDTH    = 8,
    parameter int DESC_DEPTH    = 16,
    parameter int MAX_PKT_WORDS = 20
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  wr_start_in,
    input  logic                  wr_word_in,
    input  logic                  wr_commit_in,
    input  logic [3:0]            wr_last_bytes_in,
    input  logic                  wr_abort_in,
    output logic [ADDR_WIDTH-1:0] wr_addr_out,
    output logic                  wr_enabl_out,
    output logic                  desc_valid_out,
    input  logic                  desc_ready_in,
    output logic [ADDR_WIDTH-1:0] desc_addr_out,
    output logic [7:0]            desc_words_out,
    output logic [3:0]            desc_last_bytes_out,
    input  logic                  rel_in,
    output logic [15:0]           stat_drop_cnt
);
    // DESC_DEPTH must be a power of two and at least 2.
    localparam int          FW      = $clog2(DESC_DEPTH);
    localparam logic [7:0]  MAX_W   = 8'(MAX_PKT_WORDS);
    localparam logic [FW:0] DEPTH_C = (FW+1)'(DESC_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_RECV, W_OVF} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_OFFER, R_BUSY} rstate_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            words;
        logic [3:0]            lb;
    } desc_t;

    wstate_t               wst, wst_n;
    rstate_t               rd_st, rd_st_n;
    logic [ADDR_WIDTH-1:0] wp_c, wp_c_n, wp_s, wp_s_n, rp, rp_n;
    logic [ADDR_WIDTH-1:0] free, n_wp;
    logic [7:0]            wcnt, wcnt_n, n_words, issued, issued_n;
    logic                  accept, ovf_now, push, pop, load, drop_inc;

    desc_t                 fifo_mem [DESC_DEPTH];
    logic [FW-1:0]         fifo_wr, fifo_rd;
    logic [FW:0]           fifo_cnt, fifo_cnt_n;
    logic                  fifo_full, fifo_empty;

    // One slot is always kept empty so wp_s == rp means an empty ring.
    assign free       = rp - wp_s - ADDR_WIDTH'(1);
    assign fifo_full  = (fifo_cnt == DEPTH_C);
    assign fifo_empty = (fifo_cnt == '0);

    // A start pulse takes precedence over a word in the same cycle.
    assign accept  = (wst == W_RECV) && wr_word_in && !wr_start_in &&
                     (free != '0) && (wcnt < MAX_W);
    assign ovf_now = (wst == W_RECV) && wr_word_in && !wr_start_in && !accept;
    assign n_words = wcnt + {7'd0, accept};
    assign n_wp    = wp_s + {{(ADDR_WIDTH-1){1'b0}}, accept};

    assign wr_addr_out    = wp_s;
    assign wr_enabl_out   = accept;
    assign desc_valid_out = (rd_st == R_OFFER);

    // Write FSM: allocation, commit, rollback and drop accounting.
    always_comb begin
        wst_n    = wst;
        wp_s_n   = wp_s;
        wp_c_n   = wp_c;
        wcnt_n   = wcnt;
        push     = 1'b0;
        drop_inc = 1'b0;
        if (wr_start_in) begin
            wp_s_n = wp_c;
            wcnt_n = '0;
            wst_n  = W_RECV;
        end else begin
            case (wst)
                W_RECV: begin
                    if (wr_abort_in) begin
                        wp_s_n = wp_c;
                        wst_n  = W_IDLE;
                    end else if (wr_commit_in) begin
                        if ((n_words != '0) && !fifo_full && !ovf_now) begin
                            push   = 1'b1;
                            wp_c_n = n_wp;
                            wp_s_n = n_wp;
                        end else begin
                            wp_s_n   = wp_c;
                            drop_inc = 1'b1;
                        end
                        wst_n = W_IDLE;
                    end else if (accept) begin
                        wp_s_n = n_wp;
                        wcnt_n = n_words;
                    end else if (ovf_now) begin
                        wst_n = W_OVF;
                    end
                end
                W_OVF: begin
                    if (wr_abort_in) begin
                        wp_s_n = wp_c;
                        wst_n  = W_IDLE;
                    end else if (wr_commit_in) begin
                        wp_s_n   = wp_c;
                        drop_inc = 1'b1;
                        wst_n    = W_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read FSM: offer head descriptor, hand over on ready, free on release.
    always_comb begin
        rd_st_n  = rd_st;
        rp_n     = rp;
        issued_n = issued;
        pop      = 1'b0;
        load     = 1'b0;
        case (rd_st)
            R_IDLE: begin
                if (!fifo_empty) begin
                    load    = 1'b1;
                    rd_st_n = R_OFFER;
                end
            end
            R_OFFER: begin
                if (desc_ready_in) begin
                    pop      = 1'b1;
                    issued_n = desc_words_out;
                    rd_st_n  = R_BUSY;
                end
            end
            R_BUSY: begin
                if (rel_in) begin
                    rp_n    = rp + ADDR_WIDTH'(issued);
                    rd_st_n = R_IDLE;
                end
            end
            default: rd_st_n = R_IDLE;
        endcase
    end

    // Descriptor FIFO occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        fifo_cnt_n = fifo_cnt;
        if (push && !pop)      fifo_cnt_n = fifo_cnt + (FW+1)'(1);
        else if (pop && !push) fifo_cnt_n = fifo_cnt - (FW+1)'(1);
    end

    // Descriptor storage holds data only, so it needs no reset.
    always_ff @(posedge clk_in) begin
        if (push) fifo_mem[fifo_wr] <= desc_t'({wp_c, n_words, wr_last_bytes_in});
    end

    // Control state, pointers, registered descriptor outputs and drop counter.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            wst                 <= W_IDLE;
            rd_st               <= R_IDLE;
            wp_c                <= '0;
            wp_s                <= '0;
            rp                  <= '0;
            wcnt                <= '0;
            issued              <= '0;
            fifo_wr             <= '0;
            fifo_rd             <= '0;
            fifo_cnt            <= '0;
            desc_addr_out       <= '0;
            desc_words_out      <= '0;
            desc_last_bytes_out <= '0;
            stat_drop_cnt       <= '0;
        end else begin
            wst      <= wst_n;
            rd_st    <= rd_st_n;
            wp_c     <= wp_c_n;
            wp_s     <= wp_s_n;
            rp       <= rp_n;
            wcnt     <= wcnt_n;
            issued   <= issued_n;
            fifo_cnt <= fifo_cnt_n;
            if (push) fifo_wr <= fifo_wr + FW'(1);
            if (pop)  fifo_rd <= fifo_rd + FW'(1);
            if (load) begin
                desc_addr_out       <= fifo_mem[fifo_rd].addr;
                desc_words_out      <= fifo_mem[fifo_rd].words;
                desc_last_bytes_out <= fifo_mem[fifo_rd].lb;
            end
            if (drop_inc && (stat_drop_cnt != 16'hFFFF))
                stat_drop_cnt <= stat_drop_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_rx_buf_scheduler.sv
// Scoreboard bench for rx_buf_scheduler: stimulus tasks queue the expected
// write addresses and descriptors, a negedge monitor pops and compares them.
module tb_rx_buf_scheduler;
    logic       clk_in = 1'b0;
    logic       rst_n_in = 1'b0;
    logic       wr_start_in = 1'b0, wr_word_in = 1'b0, wr_commit_in = 1'b0, wr_abort_in = 1'b0;
    logic [3:0] wr_last_bytes_in = 4'd0;
    logic [7:0] wr_addr_out;
    logic       wr_enabl_out, desc_valid_out;
    logic       desc_ready_in = 1'b0, rel_in = 1'b0;
    logic [7:0] desc_addr_out, desc_words_out;
    logic [3:0] desc_last_bytes_out;
    logic [15:0] stat_drop_cnt;

    int checks = 0;
    int failures = 0;
    logic [7:0]  exp_wr[$];
    logic [19:0] exp_desc[$];

    rx_buf_scheduler #(.ADDR_WIDTH(8), .DESC_DEPTH(16), .MAX_PKT_WORDS(20)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .wr_start_in(wr_start_in), .wr_word_in(wr_word_in), .wr_commit_in(wr_commit_in),
        .wr_last_bytes_in(wr_last_bytes_in), .wr_abort_in(wr_abort_in),
        .wr_addr_out(wr_addr_out), .wr_enabl_out(wr_enabl_out),
        .desc_valid_out(desc_valid_out), .desc_ready_in(desc_ready_in),
        .desc_addr_out(desc_addr_out), .desc_words_out(desc_words_out),
        .desc_last_bytes_out(desc_last_bytes_out), .rel_in(rel_in),
        .stat_drop_cnt(stat_drop_cnt)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe and every descriptor handshake must match the queues.
    always @(negedge clk_in) begin
        if (rst_n_in) begin
            if (wr_enabl_out) begin
                if (exp_wr.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_write: got addr %0d expected no write", wr_addr_out);
                end else begin
                    chk("wr_addr", {24'd0, wr_addr_out}, {24'd0, exp_wr.pop_front()});
                end
            end
            if (desc_valid_out && desc_ready_in) begin
                if (exp_desc.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_desc: got %0h expected none",
                             {desc_addr_out, desc_words_out, desc_last_bytes_out});
                end else begin
                    chk("desc", {12'd0, desc_addr_out, desc_words_out, desc_last_bytes_out},
                        {12'd0, exp_desc.pop_front()});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0;
        {wr_start_in, wr_word_in, wr_commit_in, wr_abort_in, desc_ready_in, rel_in} = '0;
        step(); step();
        exp_wr.delete();
        exp_desc.delete();
        rst_n_in = 1'b1;
    endtask

    task automatic pkt_start();
        wr_start_in = 1'b1; step(); wr_start_in = 1'b0;
    endtask

    task automatic word(input bit wr, input logic [7:0] a);
        if (wr) exp_wr.push_back(a);
        wr_word_in = 1'b1; step(); wr_word_in = 1'b0;
    endtask

    task automatic commit(input logic [3:0] lb, input bit good, input logic [7:0] a, input logic [7:0] n);
        if (good) exp_desc.push_back({a, n, lb});
        wr_commit_in = 1'b1; wr_last_bytes_in = lb; step(); wr_commit_in = 1'b0;
    endtask

    task automatic abort(input bit with_commit);
        wr_abort_in = 1'b1; wr_commit_in = with_commit; step();
        wr_abort_in = 1'b0; wr_commit_in = 1'b0;
    endtask

    // Accept and release every queued descriptor, bounded by a cycle budget.
    task automatic drain();
        desc_ready_in = 1'b1;
        for (int i = 0; i < 400 && exp_desc.size() > 0; i++) begin
            if (desc_valid_out) begin
                step(); rel_in = 1'b1; step(); rel_in = 1'b0;
            end else begin
                step();
            end
        end
        desc_ready_in = 1'b0;
        checks++;
        if (exp_desc.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: got %0d descriptors pending expected 0", exp_desc.size());
        end
    endtask

    task automatic release_one();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (desc_valid_out) seen = 1'b1; else step();
        end
        chk("release_one_valid", {31'd0, desc_valid_out}, 32'd1);
        desc_ready_in = 1'b1; step(); desc_ready_in = 1'b0;
        rel_in = 1'b1; step(); rel_in = 1'b0;
    endtask

    task automatic queues_empty(input string name);
        chk({name, "_wr_pending"}, exp_wr.size(), 0);
        chk({name, "_desc_pending"}, exp_desc.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Test 1: reset state, basic 3-word packet, offer latency and hold.
        do_reset();
        chk("rst_desc_valid", {31'd0, desc_valid_out}, 0);
        chk("rst_wr_enabl", {31'd0, wr_enabl_out}, 0);
        chk("rst_drop", {16'd0, stat_drop_cnt}, 0);
        chk("rst_desc_fields", {12'd0, desc_addr_out, desc_words_out, desc_last_bytes_out}, 0);
        pkt_start();
        for (int i = 0; i < 3; i++) word(1'b1, 8'(i));
        commit(4'd4, 1'b1, 8'd0, 8'd3);
        chk("t1_valid_same_cycle", {31'd0, desc_valid_out}, 0);
        step();
        chk("t1_valid_next_cycle", {31'd0, desc_valid_out}, 1);
        step(); step(); step();
        chk("t1_valid_held", {31'd0, desc_valid_out}, 1);
        chk("t1_fields_held", {12'd0, desc_addr_out, desc_words_out, desc_last_bytes_out}, {12'd0, 8'd0, 8'd3, 4'd4});
        drain();
        queues_empty("t1");

        // Test 2: abort rolls back; abort beats a simultaneous commit.
        do_reset();
        pkt_start(); word(1'b1, 8'd0); word(1'b1, 8'd1); abort(1'b0);
        pkt_start(); word(1'b1, 8'd0); commit(4'd7, 1'b1, 8'd0, 8'd1);
        pkt_start(); word(1'b1, 8'd1); abort(1'b1);
        pkt_start(); word(1'b1, 8'd1); commit(4'd2, 1'b1, 8'd1, 8'd1);
        drain();
        chk("t2_drop", {16'd0, stat_drop_cnt}, 0);
        queues_empty("t2");

        // Test 3: over-length packet dropped, committed pointer unchanged.
        do_reset();
        pkt_start();
        for (int i = 0; i < 20; i++) word(1'b1, 8'(i));
        word(1'b0, 8'd0);
        commit(4'd1, 1'b0, 8'd0, 8'd0);
        step(); step();
        chk("t3_no_desc", {31'd0, desc_valid_out}, 0);
        chk("t3_drop", {16'd0, stat_drop_cnt}, 1);
        pkt_start(); word(1'b1, 8'd0); commit(4'd5, 1'b1, 8'd0, 8'd1);
        drain();
        queues_empty("t3");

        // Test 4: fill the ring, overflow, release head, wrap into freed space.
        do_reset();
        for (int p = 0; p < 12; p++) begin
            pkt_start();
            for (int i = 0; i < 20; i++) word(1'b1, 8'(p * 20 + i));
            commit(4'd10, 1'b1, 8'(p * 20), 8'd20);
        end
        pkt_start();
        for (int i = 0; i < 15; i++) word(1'b1, 8'(240 + i));
        commit(4'd10, 1'b1, 8'd240, 8'd15);
        pkt_start(); word(1'b0, 8'd0); word(1'b0, 8'd0); commit(4'd3, 1'b0, 8'd0, 8'd0);
        chk("t4_drop", {16'd0, stat_drop_cnt}, 1);
        release_one();
        pkt_start();
        word(1'b1, 8'd255);
        for (int i = 0; i < 4; i++) word(1'b1, 8'(i));
        commit(4'd3, 1'b1, 8'd255, 8'd5);
        drain();
        chk("t4_drop_final", {16'd0, stat_drop_cnt}, 1);
        queues_empty("t4");

        // Test 5: advance both pointers to 250, then a 10-word wrapping packet.
        do_reset();
        chk("t5_rst_drop", {16'd0, stat_drop_cnt}, 0);
        for (int p = 0; p < 12; p++) begin
            pkt_start();
            for (int i = 0; i < 20; i++) word(1'b1, 8'(p * 20 + i));
            commit(4'd9, 1'b1, 8'(p * 20), 8'd20);
        end
        pkt_start();
        for (int i = 0; i < 10; i++) word(1'b1, 8'(240 + i));
        commit(4'd9, 1'b1, 8'd240, 8'd10);
        drain();
        pkt_start();
        for (int i = 0; i < 10; i++) word(1'b1, 8'(250 + i));
        commit(4'd6, 1'b1, 8'd250, 8'd10);
        drain();
        queues_empty("t5");

        // Test 6: descriptor FIFO full drop, push+pop same cycle, word+commit same cycle.
        do_reset();
        for (int p = 0; p < 16; p++) begin
            pkt_start(); word(1'b1, 8'(p)); commit(4'd1, 1'b1, 8'(p), 8'd1);
        end
        pkt_start(); word(1'b1, 8'd16); commit(4'd1, 1'b0, 8'd0, 8'd0);
        chk("t6_fifo_full_drop", {16'd0, stat_drop_cnt}, 1);
        drain();
        pkt_start(); word(1'b1, 8'd16); commit(4'd3, 1'b1, 8'd16, 8'd1);
        pkt_start(); word(1'b1, 8'd17); commit(4'd4, 1'b1, 8'd17, 8'd1);
        pkt_start(); word(1'b1, 8'd18);
        exp_wr.push_back(8'd19);
        exp_desc.push_back({8'd18, 8'd2, 4'd9});
        wr_word_in = 1'b1; wr_commit_in = 1'b1; wr_last_bytes_in = 4'd9; desc_ready_in = 1'b1;
        step();
        wr_word_in = 1'b0; wr_commit_in = 1'b0; desc_ready_in = 1'b0;
        rel_in = 1'b1; step(); rel_in = 1'b0;
        drain();
        chk("t6_drop_final", {16'd0, stat_drop_cnt}, 1);
        queues_empty("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
